// File: rtl/namuru_tb_ctrl.sv
// Namuru timebase controller: stages TIC/accum divides until reload, raises the accum interrupt, counts TIC epochs.
// Optional overrun detection (missed, missed_cnt) is built only when NAMURU_TB_MISSED_EN is defined.
module namuru_tb_ctrl #(
  parameter int DIV_W   = 24,
  parameter int EPOCH_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               wr_tic,
  input  logic               wr_accum,
  input  logic [DIV_W-1:0]   wdata,
  input  logic               pre_tic_enable,
  input  logic               accum_enable,
  input  logic               irq_ack,
  input  logic               epoch_clr,
  output logic [DIV_W-1:0]   tic_divide,
  output logic [DIV_W-1:0]   accum_divide,
  output logic               pend_tic,
  output logic               pend_accum,
  output logic               tic_applied,
  output logic               accum_applied,
  output logic               accum_irq,
  output logic               missed,
  output logic [7:0]         missed_cnt,
  output logic [EPOCH_W-1:0] tic_epoch
);

  typedef enum logic {IDLE, PEND} ch_state_t;

  localparam logic [DIV_W-1:0] TIC_RST_DIV   = DIV_W'(24'h18FFFF);
  localparam logic [DIV_W-1:0] ACCUM_RST_DIV = DIV_W'(24'h001FFF);

  logic [1:0] wr;
  logic [1:0] rld;

  assign wr  = {wr_accum, wr_tic};
  assign rld = {accum_enable, pre_tic_enable};

  // Channel 0 is TIC, channel 1 is accumulation; both share the same staging FSM.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic [DIV_W-1:0] RST_DIV = (gi == 0) ? TIC_RST_DIV : ACCUM_RST_DIV;

      ch_state_t        state_reg;
      logic [DIV_W-1:0] shadow_reg;
      logic [DIV_W-1:0] div_reg;
      logic             xfer_reg;
      logic             applied_reg;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          state_reg   <= IDLE;
          shadow_reg  <= RST_DIV;
          div_reg     <= RST_DIV;
          xfer_reg    <= 1'b0;
          applied_reg <= 1'b0;
        end else begin
          xfer_reg    <= 1'b0;
          applied_reg <= xfer_reg;
          case (state_reg)
            IDLE: begin
              if (wr[gi]) begin
                state_reg  <= PEND;
                shadow_reg <= wdata;
              end
            end
            PEND: begin
              // A write on the reload edge wins and defers the transfer to the next reload.
              if (wr[gi]) begin
                shadow_reg <= wdata;
              end else if (rld[gi]) begin
                div_reg   <= shadow_reg;
                state_reg <= IDLE;
                xfer_reg  <= 1'b1;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      if (gi == 0) begin : g_tic_out
        assign tic_divide  = div_reg;
        assign pend_tic    = (state_reg == PEND);
        assign tic_applied = applied_reg;
      end else begin : g_accum_out
        assign accum_divide  = div_reg;
        assign pend_accum    = (state_reg == PEND);
        assign accum_applied = applied_reg;
      end
    end
  endgenerate

  logic irq_reg;

  // A fresh accumulation event outranks a coincident acknowledge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      irq_reg <= 1'b0;
    end else if (accum_enable) begin
      irq_reg <= 1'b1;
    end else if (irq_ack) begin
      irq_reg <= 1'b0;
    end
  end

  assign accum_irq = irq_reg;

`ifdef NAMURU_TB_MISSED_EN
  logic       missed_reg;
  logic [7:0] missed_cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      missed_reg     <= 1'b0;
      missed_cnt_reg <= 8'd0;
    end else if (irq_ack) begin
      missed_reg     <= 1'b0;
      missed_cnt_reg <= 8'd0;
    end else if (accum_enable && irq_reg) begin
      missed_reg <= 1'b1;
      if (missed_cnt_reg != 8'hFF) begin
        missed_cnt_reg <= missed_cnt_reg + 8'd1;
      end
    end
  end

  assign missed     = missed_reg;
  assign missed_cnt = missed_cnt_reg;
`else
  assign missed     = 1'b0;
  assign missed_cnt = 8'd0;
`endif

  logic [EPOCH_W-1:0] epoch_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || epoch_clr) begin
      epoch_reg <= '0;
    end else if (pre_tic_enable) begin
      epoch_reg <= epoch_reg + 1'b1;
    end
  end

  assign tic_epoch = epoch_reg;

endmodule

// File: tb/tb_namuru_tb_ctrl.sv
// Scoreboard bench for namuru_tb_ctrl: a driver pushes model predictions, a monitor pops and compares each cycle.
module tb_namuru_tb_ctrl;
  localparam int DW = 24;
  localparam int EW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          wr_tic = 1'b0, wr_accum = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          pre_tic_enable = 1'b0, accum_enable = 1'b0, irq_ack = 1'b0, epoch_clr = 1'b0;
  logic [DW-1:0] tic_divide, accum_divide;
  logic          pend_tic, pend_accum, tic_applied, accum_applied, accum_irq, missed;
  logic [7:0]    missed_cnt;
  logic [EW-1:0] tic_epoch;

  namuru_tb_ctrl #(.DIV_W(DW), .EPOCH_W(EW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_tic(wr_tic), .wr_accum(wr_accum), .wdata(wdata),
    .pre_tic_enable(pre_tic_enable), .accum_enable(accum_enable), .irq_ack(irq_ack), .epoch_clr(epoch_clr),
    .tic_divide(tic_divide), .accum_divide(accum_divide), .pend_tic(pend_tic), .pend_accum(pend_accum),
    .tic_applied(tic_applied), .accum_applied(accum_applied), .accum_irq(accum_irq), .missed(missed),
    .missed_cnt(missed_cnt), .tic_epoch(tic_epoch)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] td, ad;
    logic          pt, pa, ta, aa, irq, mis;
    logic [7:0]    mc;
    logic [EW-1:0] ep;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per channel a divide, an optional staged value and an applied notice due next cycle.
  logic [DW-1:0] m_div[2], m_stg[2];
  bit            m_has[2], m_due[2], m_app[2];
  bit            m_irq, m_missed;
  int            m_cnt, m_epoch;

  task automatic model_reset();
    m_div[0] = 24'h18FFFF; m_div[1] = 24'h001FFF;
    for (int c = 0; c < 2; c++) begin
      m_has[c] = 0; m_due[c] = 0; m_app[c] = 0; m_stg[c] = '0;
    end
    m_irq = 0; m_missed = 0; m_cnt = 0; m_epoch = 0;
  endtask

  task automatic step(input bit rst, input bit wt, input bit wa, input logic [DW-1:0] wd,
                      input bit pt, input bit ae, input bit ack, input bit ec);
    bit   w[2], r[2];
    exp_t e;
    sys_rst = rst; wr_tic = wt; wr_accum = wa; wdata = wd;
    pre_tic_enable = pt; accum_enable = ae; irq_ack = ack; epoch_clr = ec;
    w[0] = wt; w[1] = wa; r[0] = pt; r[1] = ae;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_app[c] = m_due[c];
        m_due[c] = 0;
        if (w[c]) begin
          m_has[c] = 1; m_stg[c] = wd;
        end else if (r[c] && m_has[c]) begin
          m_div[c] = m_stg[c]; m_has[c] = 0; m_due[c] = 1;
        end
      end
      if (ack) begin
        m_missed = 0; m_cnt = 0;
      end else if (ae && m_irq) begin
        m_missed = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      if (ae) m_irq = 1;
      else if (ack) m_irq = 0;
      if (ec) m_epoch = 0;
      else if (pt) m_epoch = (m_epoch + 1) % (1 << EW);
    end
    e.td = m_div[0]; e.ad = m_div[1];
    e.pt = m_has[0]; e.pa = m_has[1];
    e.ta = m_app[0]; e.aa = m_app[1];
    e.irq = m_irq;
`ifdef NAMURU_TB_MISSED_EN
    e.mis = m_missed; e.mc = 8'(m_cnt);
`else
    e.mis = 1'b0; e.mc = 8'd0;
`endif
    e.ep = EW'(m_epoch);
    exp_q.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tic_divide", 32'(tic_divide), 32'(e.td));
        chk("accum_divide", 32'(accum_divide), 32'(e.ad));
        chk("pend_tic", 32'(pend_tic), 32'(e.pt));
        chk("pend_accum", 32'(pend_accum), 32'(e.pa));
        chk("tic_applied", 32'(tic_applied), 32'(e.ta));
        chk("accum_applied", 32'(accum_applied), 32'(e.aa));
        chk("accum_irq", 32'(accum_irq), 32'(e.irq));
        chk("missed", 32'(missed), 32'(e.mis));
        chk("missed_cnt", 32'(missed_cnt), 32'(e.mc));
        chk("tic_epoch", 32'(tic_epoch), 32'(e.ep));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge sys_clk);
    repeat (3) step(1, 0, 0, '0, 0, 0, 0, 0);
    idle(2);
    $display("reset state checked");

    step(0, 1, 0, 24'h000009, 0, 0, 0, 0);
    idle(19);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    idle(3);
    $display("tic write 0x9 applied at reload");

    step(0, 0, 1, 24'h000FFF, 0, 1, 0, 0);
    idle(3);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, '0, 0, 0, 1, 0);
    $display("accum write coincident with reload deferred");

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0, 0, 1, 0, 0);
      idle(1);
    end
    step(0, 0, 0, '0, 0, 0, 1, 0);
    idle(1);
    $display("three unacked accum events then ack");

    step(0, 0, 0, '0, 0, 1, 1, 0);
    idle(1);
    repeat (300) step(0, 0, 0, '0, 0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1, 0);
    $display("missed_cnt saturation run");

    step(0, 0, 0, '0, 0, 0, 0, 1);
    repeat (16) step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 1);
    idle(1);
    $display("epoch wrap and clear");

    step(0, 1, 0, 24'h000005, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    idle(2);
    $display("reset discards staged tic value");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           DW'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
    end
    $display("random run of 3000 cycles");

    @(posedge sys_clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
